add_serial: RTL

//  Multi-cycle ripple adder: generalises the 1-bit full-adder cell to WIDTH-bit operands.

---
 rtl/add_serial_if.sv | 30 +++
 rtl/add_serial.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/add_serial_if.sv
// Valid/ready bundle carrying operands into add_serial and its result back out.
// The sub signal exists only when ADD_SERIAL_SUB_EN is defined.
interface add_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
`ifdef ADD_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

`ifdef ADD_SERIAL_SUB_EN
    modport master (output in_valid, a, b, c, sub, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c, sub, out_ready,
                    output in_ready, out_valid, sum, c_out);
`else
    modport master (output in_valid, a, b, c, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c, out_ready,
                    output in_ready, out_valid, sum, c_out);
`endif
endinterface

// File: rtl/add_serial.sv
// Multi-cycle ripple adder: CHUNK bits per clock through a registered carry.
// Define ADD_SERIAL_SUB_EN to add a subtract mode (a + ~b + 1) selected by bus.sub.
module add_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst,
    add_serial_if.slave  bus
);
    localparam int STEPS  = WIDTH / CHUNK;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("add_serial: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               last_step;
    logic               sub_in;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic               c_out_reg;
    logic [STEP_W-1:0]  step;
    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   slice_sum;
    logic [CHUNK:0]     chain;

`ifdef ADD_SERIAL_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept    = bus.in_valid && in_ready;
    assign last_step = (step == STEP_W'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the active slice and ripple it through CHUNK full-adder cells.
    always_comb begin
        a_slice   = '0;
        b_slice   = '0;
        slice_sum = '0;
        chain     = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (step == STEP_W'(k)) begin
                a_slice = a_reg[k*CHUNK +: CHUNK];
                b_slice = b_reg[k*CHUNK +: CHUNK];
            end
        end
        chain[0] = carry_reg;
        for (int i = 0; i < CHUNK; i++) begin
            slice_sum[i] = a_slice[i] ^ b_slice[i] ^ chain[i];
            chain[i+1]   = (a_slice[i] & b_slice[i]) | (chain[i] & (a_slice[i] ^ b_slice[i]));
        end
    end

    // Subtraction is folded in at accept: b is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            step      <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= sub_in ? ~bus.b : bus.b;
                carry_reg <= sub_in ? 1'b1 : bus.c;
                step      <= '0;
            end
        end else if (state == BUSY) begin
            for (int k = 0; k < STEPS; k++) begin
                if (step == STEP_W'(k)) begin
                    sum_reg[k*CHUNK +: CHUNK] <= slice_sum;
                end
            end
            carry_reg <= chain[CHUNK];
            step      <= step + 1'b1;
            if (last_step) begin
                c_out_reg <= chain[CHUNK];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;

endmodule
